// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared funct3 codes and FSM state type for the MEM-stage unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_align.sv
// ============================================================================
// Module   : load_store_align
// Brief    : Combinational lane alignment: byte enables, replicated store data,
//            sign/zero-extended load data and misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = load_word[8*addr_lo +: 8];
    assign w_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_word;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                if (is_store) be = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'd0, w_byte};
            end
            F3_H, F3_HU: begin
                if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                              : {16'd0, w_half};
                misaligned = addr_lo[0];
            end
            // F3_W and the undefined codes all behave as a full word
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access_stage.sv
// ============================================================================
// Module   : memory_access_stage
// Brief    : MEM-stage data-memory access unit with req/ready port and stall.
//            Optional BUSY timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memreadm,
    input  logic                  memwritem,
    input  logic [2:0]            funct3m,
    input  logic [DATA_WIDTH-1:0] aluresultm,
    input  logic [DATA_WIDTH-1:0] writedatam,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] readdatam,
    output logic                  stallm,
`ifdef MEM_STAGE_TIMEOUT_EN
    output logic                  access_faultm,
`endif
    output logic                  misalignedm
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("memory_access_stage: DATA_WIDTH must be 32, TIMEOUT_CYCLES >= 1");
    end

    mem_state_t            r_state;
    logic                  r_mem_req;
    logic [DATA_WIDTH-1:0] r_capture;
    logic                  w_access;
    logic                  w_misaligned;
    logic                  w_fault;
    logic [DATA_WIDTH-1:0] w_load_ext;

    assign w_access = memreadm | memwritem;

    load_store_align u_align (
        .addr_lo    (aluresultm[1:0]),
        .funct3     (funct3m),
        .is_store   (memwritem),
        .store_data (writedatam),
        .load_word  (r_capture),
        .be         (mem_be),
        .wdata      (mem_wdata),
        .load_data  (w_load_ext),
        .misaligned (w_misaligned)
    );

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_fault;

    assign w_fault       = r_fault;
    assign access_faultm = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_capture <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            r_cnt     <= '0;
            r_fault   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access && !w_misaligned) begin
                        r_state   <= BUSY;
                        r_mem_req <= 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_capture <= mem_rdata;
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else if (r_cnt == c_cnt_last) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
                    r_fault <= 1'b0;
`endif
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Request fields come straight from the held EX/MEM values; the pipeline is frozen in BUSY
    assign mem_req     = r_mem_req;
    assign mem_we      = memwritem;
    assign mem_addr    = {aluresultm[DATA_WIDTH-1:2], 2'b00};

    assign stallm      = ((r_state == IDLE) && w_access && !w_misaligned) || (r_state == BUSY);
    assign misalignedm = (r_state == IDLE) && w_access && w_misaligned;
    assign readdatam   = ((r_state == DONE) && memreadm && !w_fault) ? w_load_ext : '0;

endmodule

`default_nettype wire

// File: tb/tb_memory_access_stage.sv
// ============================================================================
// Module   : tb_memory_access_stage
// Brief    : Self-checking bench: vector table plus reset/timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memreadm = 1'b0;
    logic        memwritem = 1'b0;
    logic [2:0]  funct3m = 3'd0;
    logic [31:0] aluresultm = 32'd0;
    logic [31:0] writedatam = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] readdatam;
    logic        stallm;
    logic        misalignedm;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic        access_faultm;
`endif

    memory_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadm   (memreadm),
        .memwritem  (memwritem),
        .funct3m    (funct3m),
        .aluresultm (aluresultm),
        .writedatam (writedatam),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .readdatam  (readdatam),
        .stallm     (stallm),
`ifdef MEM_STAGE_TIMEOUT_EN
        .access_faultm (access_faultm),
`endif
        .misalignedm (misalignedm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        memreadm  = 1'b0;
        memwritem = 1'b0;
        funct3m   = 3'd0;
        aluresultm = 32'd0;
        writedatam = 32'd0;
    endtask

    // Entered at posedge+1; returns at posedge+1 of the cycle after DONE
    task automatic run_vec(input vec_t v, input int idx);
        int          stalls;
        logic [31:0] exp;
        memreadm   = v.rd;
        memwritem  = v.wr;
        funct3m    = v.f3;
        aluresultm = v.addr;
        writedatam = v.wdata;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;
        #1;
        if (v.exp_mis) begin
            check($sformatf("v%0d misaligned", idx), {31'd0, misalignedm}, 32'd1);
            check($sformatf("v%0d mis_stall", idx), {31'd0, stallm}, 32'd0);
            check($sformatf("v%0d mis_readdata", idx), readdatam, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d mis_noreq", idx), {31'd0, mem_req}, 32'd0);
            set_idle();
            return;
        end
        check($sformatf("v%0d idle_stall", idx), {31'd0, stallm}, 32'd1);
        check($sformatf("v%0d idle_noreq", idx), {31'd0, mem_req}, 32'd0);
        sb_q.push_back(v.rd ? v.exp_rdata : 32'd0);
        stalls = 1;
        for (int k = 0; k < v.wait_n; k++) begin
            @(posedge clk); #1;
            if (stallm) stalls++;
            check($sformatf("v%0d req", idx), {31'd0, mem_req}, 32'd1);
            if (k == 0) begin
                check($sformatf("v%0d we", idx), {31'd0, mem_we}, {31'd0, v.wr});
                check($sformatf("v%0d addr", idx), mem_addr, v.addr & 32'hFFFF_FFFC);
                check($sformatf("v%0d be", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
                if (v.wr) check($sformatf("v%0d wdata", idx), mem_wdata, v.exp_wdata);
            end
            if (k == v.wait_n - 1) begin
                mem_ready = 1'b1;
                mem_rdata = v.rdata;
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        #1;
        check($sformatf("v%0d done_stall", idx), {31'd0, stallm}, 32'd0);
        check($sformatf("v%0d done_noreq", idx), {31'd0, mem_req}, 32'd0);
        check($sformatf("v%0d stall_cycles", idx), stalls, v.wait_n + 1);
`ifdef MEM_STAGE_TIMEOUT_EN
        check($sformatf("v%0d no_fault", idx), {31'd0, access_faultm}, 32'd0);
`endif
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL v%0d scoreboard: queue empty", idx);
        end else begin
            exp = sb_q.pop_front();
            check($sformatf("v%0d readdatam", idx), readdatam, exp);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        //            rd    wr    f3    addr          wdata         rdata         wt be       exp_wdata     exp_rdata     mis
        vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0000, 2, 4'b1111, 32'h0,        32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        1, 4'b1111, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        2, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0006, 32'h0,        32'h8001_1234, 1, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0004, 32'h0,        32'h8001_F00F, 4, 4'b1111, 32'h0,        32'h0000_F00F, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0203, 32'h1111_2222, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h0000_0020, 32'h0,        32'h1122_3344, 2, 4'b1111, 32'h0,        32'h1122_3344, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd7, 32'h0000_0022, 32'h0,        32'h0,        1, 4'b1111, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1, 4'b1111, 32'h0,        32'h0000_007F, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset stallm", {31'd0, stallm}, 32'd0);
        check("reset readdatam", readdatam, 32'd0);
        check("reset misalignedm", {31'd0, misalignedm}, 32'd0);
        rst = 1'b0;

        // A ready pulse while idle must not start or complete anything
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("idle ready ignored req", {31'd0, mem_req}, 32'd0);
        check("idle ready ignored stall", {31'd0, stallm}, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
        check("scoreboard drained", sb_q.size(), 32'd0);

        // Reset while BUSY: request drops, late ready ignored
        memreadm = 1'b1; funct3m = 3'd2; aluresultm = 32'h0000_0300;
        @(posedge clk); #1;
        check("rstbusy req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        check("rstbusy req dropped", {31'd0, mem_req}, 32'd0);
        check("rstbusy stall", {31'd0, stallm}, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("rstbusy late ready req", {31'd0, mem_req}, 32'd0);
        check("rstbusy late ready stall", {31'd0, stallm}, 32'd0);
        check("rstbusy readdatam", readdatam, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
        memreadm = 1'b1; funct3m = 3'd2; aluresultm = 32'h0000_0040;
        #1;
        check("tmo idle stall", {31'd0, stallm}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("tmo busy%0d stall", k), {31'd0, stallm}, 32'd1);
            check($sformatf("tmo busy%0d req", k), {31'd0, mem_req}, 32'd1);
        end
        @(posedge clk); #1;
        check("tmo fault", {31'd0, access_faultm}, 32'd1);
        check("tmo stall", {31'd0, stallm}, 32'd0);
        check("tmo readdatam", readdatam, 32'd0);
        @(posedge clk); #1;
        set_idle();
        #1;
        check("tmo fault cleared", {31'd0, access_faultm}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
